// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin grant sequencer for one shared ALU; define ARB_TIMEOUT_EN to add the busy watchdog and timeout_o
module alu_rr_dec #(
    parameter int N      = 2,
    parameter bit ACTIVE = 1'b1
) (
    input  logic [N-1:0]      i_sel,
    input  logic              i_en,
    output logic [(1<<N)-1:0] o_dec
);
    localparam int M = 1 << N;
    logic [M-1:0] w_hot;
    assign w_hot = i_en ? (M'(1) << i_sel) : '0;
    assign o_dec = ACTIVE ? w_hot : ~w_hot;
endmodule

module alu_rr_arbiter #(
    parameter int REQ_W       = 2,
    parameter bit ACTIVE      = 1'b1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [(1<<REQ_W)-1:0]   req_i,
    input  logic                    op_done_i,
    output logic [(1<<REQ_W)-1:0]   gnt_o,
    output logic [REQ_W-1:0]        gnt_idx_o,
    output logic                    start_o,
    output logic                    busy_o
`ifdef ARB_TIMEOUT_EN
    ,output logic                   timeout_o
`endif
);
    localparam int NREQ = 1 << REQ_W;
    localparam logic [NREQ-1:0] GNT_OFF = {NREQ{~ACTIVE}};

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state;
    logic [REQ_W-1:0]  r_ptr;
    logic [REQ_W-1:0]  r_idx;
    logic [NREQ-1:0]   r_gnt;
    logic              r_start;
    logic              r_busy;
    logic [REQ_W-1:0]  w_win;
    logic [NREQ-1:0]   w_dec;
    logic              w_end;

    // rotating scan: the requester at the smallest offset from r_ptr wins
    always_comb begin
        w_win = r_ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_i[r_ptr + REQ_W'(i)]) w_win = r_ptr + REQ_W'(i);
    end

    alu_rr_dec #(.N(REQ_W), .ACTIVE(ACTIVE)) u_dec (
        .i_sel (w_win),
        .i_en  (1'b1),
        .o_dec (w_dec)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);
    logic [15:0] r_cnt;
    logic        r_to;
    assign w_end     = op_done_i || r_cnt == LIMIT;
    assign timeout_o = r_to;

    // watchdog: counts BUSY cycles from zero and flags a release that had no completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_to  <= 1'b0;
        end else begin
            r_to  <= r_state == BUSY && !op_done_i && r_cnt == LIMIT;
            r_cnt <= r_state == BUSY ? r_cnt + 16'd1 : '0;
        end
    end
`else
    assign w_end = op_done_i;
`endif

    // grant FSM: issue on any request when idle, hold until release, then rotate past the winner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= GNT_OFF;
            r_idx   <= '0;
            r_ptr   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: if (|req_i) begin
                    r_state <= BUSY;
                    r_idx   <= w_win;
                    r_gnt   <= w_dec;
                    r_start <= 1'b1;
                    r_busy  <= 1'b1;
                end
                BUSY: if (w_end) begin
                    r_state <= IDLE;
                    r_gnt   <= GNT_OFF;
                    r_busy  <= 1'b0;
                    r_ptr   <= r_idx + REQ_W'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_idx_o = r_idx;
    assign start_o   = r_start;
    assign busy_o    = r_busy;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model
module tb_alu_rr_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, op_done, start, busy;
    logic [3:0] req, gnt;
    logic [1:0] idx;
    logic       p_rst_n, p_done, p_start, p_busy;
    logic [3:0] p_req, p_gnt;
    logic [1:0] p_idx;
`ifdef ARB_TIMEOUT_EN
    logic       tmo, p_tmo;
`endif

    alu_rr_arbiter #(.REQ_W(2), .ACTIVE(1'b1), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .op_done_i(op_done),
        .gnt_o(gnt), .gnt_idx_o(idx), .start_o(start), .busy_o(busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout_o(tmo)
`endif
    );

    alu_rr_arbiter #(.REQ_W(2), .ACTIVE(1'b0), .TIMEOUT_CYC(TO)) dut_p (
        .clk(clk), .rst_n(p_rst_n), .req_i(p_req), .op_done_i(p_done),
        .gnt_o(p_gnt), .gnt_idx_o(p_idx), .start_o(p_start), .busy_o(p_busy)
`ifdef ARB_TIMEOUT_EN
        , .timeout_o(p_tmo)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    bit m_busy, m_start, m_to;
    int m_idx, m_ptr, m_cnt;

    function automatic logic [3:0] m_gnt();
        return m_busy ? 4'(1 << m_idx) : 4'b0000;
    endfunction

    task automatic model_step();
        bit expire;
        m_start = 0;
        m_to = 0;
        if (!rst_n) begin
            m_busy = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (req != 0) begin
                for (int k = 0; k < NREQ; k++)
                    if (req[(m_ptr + k) % NREQ]) begin
                        m_idx = (m_ptr + k) % NREQ;
                        break;
                    end
                m_busy = 1; m_start = 1; m_cnt = 0;
            end
        end else begin
            expire = 0;
`ifdef ARB_TIMEOUT_EN
            expire = (m_cnt == TO - 1);
`endif
            if (op_done || expire) begin
                m_busy = 0;
                m_ptr = (m_idx + 1) % NREQ;
                m_to = !op_done;
            end else m_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; tick(); rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; req = 4'b1111; op_done = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
            n_cmp++; if (start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", start); end
        end
        rst_n = 1;
        tick();
        n_cmp++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
        n_cmp++; if (idx !== 2'd0) begin n_fail++; $display("FAIL reset_first_idx: got %0d expected 0", idx); end
        n_cmp++; if (start !== 1'b1) begin n_fail++; $display("FAIL reset_first_start: got %b expected 1", start); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; op_done = 0;
        for (int g = 0; g < 5; g++) begin
            int n = 0;
            do begin tick(); n++; end while (start !== 1'b1 && n < 4);
            n_cmp++; if (start !== 1'b1) begin n_fail++; $display("FAIL rot_start_%0d: got %b expected 1 within 4 cycles", g, start); end
            n_cmp++; if (gnt !== exp_seq[g]) begin n_fail++; $display("FAIL rot_gnt_%0d: got %b expected %b", g, gnt, exp_seq[g]); end
            tick(); tick();
            op_done = 1; tick(); op_done = 0;
            n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL rot_idle_%0d: got gnt %b busy %b expected 0000 0", g, gnt, busy); end
        end
    endtask

    task automatic test_skip_wrap();
        do_reset();
        req = 4'b0100; op_done = 0;
        tick();
        n_cmp++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL skip_first: got %b expected 0100", gnt); end
        req = 4'b0011; op_done = 1; tick(); op_done = 0;
        tick();
        n_cmp++; if (gnt !== 4'b0001 || idx !== 2'd0) begin n_fail++; $display("FAIL skip_wrap: got %b idx %0d expected 0001 idx 0", gnt, idx); end
        op_done = 1; tick(); op_done = 0;
        tick();
        n_cmp++; if (gnt !== 4'b0010 || idx !== 2'd1) begin n_fail++; $display("FAIL skip_next: got %b idx %0d expected 0010 idx 1", gnt, idx); end
    endtask

    task automatic test_hold();
        do_reset();
        req = 4'b0010; op_done = 0;
        tick();
        req = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (gnt !== 4'b0010 || start !== 1'b0) begin n_fail++; $display("FAIL hold_%0d: got %b start %b expected 0010 start 0", c, gnt, start); end
        end
        op_done = 1; tick(); op_done = 0;
        n_cmp++; if (gnt !== 4'b0000 || idx !== 2'd1) begin n_fail++; $display("FAIL hold_release: got %b idx %0d expected 0000 idx 1", gnt, idx); end
        tick();
        n_cmp++; if (gnt !== 4'b0001 || idx !== 2'd0) begin n_fail++; $display("FAIL hold_next: got %b idx %0d expected 0001 idx 0", gnt, idx); end
    endtask

    task automatic test_polarity();
        n_cmp++; if (p_gnt !== 4'b1111 || p_busy !== 1'b0) begin n_fail++; $display("FAIL pol_idle: got %b busy %b expected 1111 0", p_gnt, p_busy); end
        p_rst_n = 1;
        tick();
        n_cmp++; if (p_gnt !== 4'b1011 || p_idx !== 2'd2 || p_start !== 1'b1) begin n_fail++; $display("FAIL pol_grant: got %b idx %0d start %b expected 1011 2 1", p_gnt, p_idx, p_start); end
        tick();
        n_cmp++; if (p_gnt !== 4'b1011 || p_start !== 1'b0) begin n_fail++; $display("FAIL pol_hold: got %b start %b expected 1011 0", p_gnt, p_start); end
        p_rst_n = 0;
        tick();
        n_cmp++; if (p_gnt !== 4'b1111) begin n_fail++; $display("FAIL pol_reset: got %b expected 1111", p_gnt); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        req = 4'b0001; op_done = 0;
        tick();
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c < 4) begin
                n_cmp++; if (tmo !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_wait_%0d: got tmo %b busy %b expected 0 1", c, tmo, busy); end
            end else begin
                n_cmp++; if (tmo !== 1'b1 || gnt !== 4'b0000) begin n_fail++; $display("FAIL to_fire: got tmo %b gnt %b expected 1 0000", tmo, gnt); end
            end
        end
        tick();
        n_cmp++; if (start !== 1'b1 || tmo !== 1'b0) begin n_fail++; $display("FAIL to_regrant: got start %b tmo %b expected 1 0", start, tmo); end
        tick(); tick(); tick();
        op_done = 1; tick(); op_done = 0;
        n_cmp++; if (tmo !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_done_wins: got tmo %b busy %b expected 0 0", tmo, busy); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = 4'($urandom);
            op_done = ($urandom_range(0, 4) == 0);
            rst_n = ($urandom_range(0, 79) != 0);
            tick();
            n_cmp++; if (gnt !== m_gnt()) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b expected %b", c, gnt, m_gnt()); end
            n_cmp++; if (idx !== 2'(m_idx)) begin n_fail++; $display("FAIL rnd_idx@%0d: got %0d expected %0d", c, idx, m_idx); end
            n_cmp++; if (start !== m_start) begin n_fail++; $display("FAIL rnd_start@%0d: got %b expected %b", c, start, m_start); end
            n_cmp++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b expected %b", c, busy, m_busy); end
`ifdef ARB_TIMEOUT_EN
            n_cmp++; if (tmo !== m_to) begin n_fail++; $display("FAIL rnd_tmo@%0d: got %b expected %b", c, tmo, m_to); end
`endif
        end
        rst_n = 1; op_done = 0;
    endtask

    initial begin
        rst_n = 0; req = 0; op_done = 0;
        p_rst_n = 0; p_req = 4'b0100; p_done = 0;
        m_busy = 0; m_start = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_hold();
        test_polarity();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
